cpu_ocimem_access_arbiter: RTL and testbench
============================================

// Module: cpu_ocimem_access_arbiter
// PURPOSE
//  Sequences and shares the Nios II on-chip debug memory (single-port RAM, 32-bit, 1-cycle read
//  latency) between two requesters: the JTAG debug path (take_action_ocimem_a/b + jdo from the
//  sysclk-domain debug module) and the CPU's debug slave port (Avalon-MM style). Round-robin
//  arbitration on conflict, auto-incrementing JTAG address register, and MonDReg/monitor_ready
//  readback toward the debug TCK logic. Sits between the jtag_debug_module wrapper and the OCI RAM.
// PARAMETERS
//  ADDR_W   8   OCI RAM word-address width (depth = 2**ADDR_W)
//  RR_INIT  0   round-robin priority after reset: 0 = CPU first, 1 = JTAG first
// PORTS
//  clk                  in   1        system clock; all logic on rising edge
//  reset                in   1        synchronous, active-high reset
//  take_action_ocimem_a in   1        JTAG cmd A pulse: load address and optionally request a read
//  take_action_ocimem_b in   1        JTAG cmd B pulse: request a write of jdo data
//  jdo                  in   38       JTAG data: [ADDR_W+1:2]=word addr (cmd A), [34:3]=wdata (cmd B), [35]=read flag (cmd A)
//  debugack             in   1        CPU halted in debug; JTAG accesses serviced only while 1
//  avl_address          in   ADDR_W   CPU word address
//  avl_read             in   1        CPU read request, held until waitrequest=0
//  avl_write            in   1        CPU write request, held until waitrequest=0
//  avl_writedata        in   32       CPU write data
//  avl_waitrequest      out  1        1 = CPU request not accepted this cycle
//  avl_readdata         out  32       CPU read data, valid with avl_readdatavalid
//  avl_readdatavalid    out  1        one-cycle pulse, exactly 1 cycle after read accept
//  ram_addr             out  ADDR_W   OCI RAM address
//  ram_we               out  1        OCI RAM write enable
//  ram_wdata            out  32       OCI RAM write data
//  ram_rdata            in   32       OCI RAM read data, 1 cycle after address
//  MonDReg              out  32       last JTAG read result
//  monitor_ready        out  1        1 = MonDReg holds a completed JTAG read
//  jtag_overrun         out  1        sticky: JTAG command arrived while one was pending
// BEHAVIOUR
//  Reset values: state=IDLE, avl_waitrequest=1, avl_readdatavalid=0, avl_readdata=0, ram_we=0,
//   MonDReg=0, monitor_ready=0, jtag_overrun=0, jtag addr reg=0, jtag pending=0, rr=RR_INIT.
//   Reset mid-access aborts it: no readdatavalid, no MonDReg update, pending request dropped.
//  JTAG front end (registered, 1-deep):
//   - cmd A: addr_reg<=jdo[ADDR_W+1:2]; monitor_ready<=0; if jdo[35] set pending read.
//   - cmd B: wdata_reg<=jdo[34:3]; monitor_ready<=0; set pending write.
//   - cmd A and B in same cycle: A wins, B ignored, jtag_overrun<=1.
//   - any cmd while pending=1: command dropped, regs unchanged, jtag_overrun<=1 (cleared only by reset).
//   - pending eligible for grant only when debugack=1; otherwise held indefinitely.
//  FSM states: IDLE, CPU_RD, JTAG_RD.
//   - IDLE: cpu_req=avl_read|avl_write; jtag_req=pending&debugack. If both, grant per rr, then rr
//     flips to the loser. Single requester granted immediately; rr unchanged.
//   - CPU grant (same cycle): avl_waitrequest=0, ram_addr=avl_address, ram_we=avl_write,
//     ram_wdata=avl_writedata. Write -> stay IDLE. Read -> CPU_RD.
//     avl_read&avl_write both set: treated as write.
//   - CPU_RD: avl_readdata<=ram_rdata, avl_readdatavalid=1 for this cycle, waitrequest=1, -> IDLE.
//   - JTAG grant: ram_addr=addr_reg; write: ram_we=1, ram_wdata=wdata_reg, pending<=0,
//     addr_reg<=addr_reg+1 (wraps 2**ADDR_W-1 -> 0), stay IDLE. Read: -> JTAG_RD.
//   - JTAG_RD: MonDReg<=ram_rdata, monitor_ready<=1, pending<=0, addr_reg+1 (wrap), -> IDLE.
//  Latency: access granted in IDLE same cycle; max 1 gap cycle between back-to-back grants
//   (read states only). Write throughput 1/cycle per requester when uncontended.
//  ram_we=0 in every cycle without a write grant; ram_addr holds last value when idle.
// TESTING
//  T1 CPU write 0x12345678 @0x05, then read @0x05 -> waitrequest=0 on accept; readdatavalid 1 cycle later, data 0x12345678.
//  T2 debugack=1; cmd A addr 0x10 read=1 after RAM[0x10]=0xCAFEF00D -> 2 cycles later MonDReg=0xCAFEF00D, monitor_ready=1, addr_reg=0x11.
//  T3 CPU write and JTAG write pending same cycle, RR_INIT=0 -> CPU granted first, JTAG next cycle; repeat conflict -> JTAG first.
//  T4 debugack=0 with JTAG write pending for 20 cycles -> no ram_we from JTAG; raise debugack -> write within 1 cycle.
//  T5 addr_reg=0xFF, cmd B write -> RAM[0xFF] written, addr_reg wraps to 0x00; second cmd B while pending -> jtag_overrun=1, dropped.
//  T6 assert reset during CPU_RD -> no readdatavalid; all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_ocimem_access_arbiter.sv
// Shares the Nios II OCI debug RAM between the JTAG debug path and the CPU
// debug slave port. Round-robin on conflict, auto-incrementing JTAG address,
// MonDReg/monitor_ready readback toward the TCK-side debug logic.
module cpu_ocimem_access_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [31:0]       avl_writedata,
  output logic              avl_waitrequest,
  output logic [31:0]       avl_readdata,
  output logic              avl_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_JTAG_RD
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;          // 1 = JTAG wins the next conflict
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [31:0]         jwdata_q, jwdata_d;
  logic                pend_q, pend_d;
  logic                pend_rd_q, pend_rd_d;
  logic [31:0]         mon_q, mon_d;
  logic                rdy_q, rdy_d;
  logic                ovr_q, ovr_d;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   raddr_q;

  logic cpu_req, jtag_req, cpu_win, jtag_win;
  logic unused_jdo;

  // Requests are suppressed during reset so an asserted reset never produces a RAM access.
  assign cpu_req  = (avl_read | avl_write) & ~reset;
  assign jtag_req = pend_q & debugack & ~reset;
  assign cpu_win  = cpu_req & (~jtag_req | ~rr_q);
  assign jtag_win = jtag_req & ~cpu_win;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign jtag_overrun  = ovr_q;

  // Arbitration, FSM next state, RAM port drive and JTAG command front end.
  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    jaddr_d           = jaddr_q;
    jwdata_d          = jwdata_q;
    pend_d            = pend_q;
    pend_rd_d         = pend_rd_q;
    mon_d             = mon_q;
    rdy_d             = rdy_q;
    ovr_d             = ovr_q;
    avl_waitrequest   = 1'b1;
    avl_readdatavalid = 1'b0;
    avl_readdata      = rdata_q;
    ram_addr          = raddr_q;
    ram_we            = 1'b0;
    ram_wdata         = avl_writedata;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && jtag_req) rr_d = cpu_win;
        if (cpu_win) begin
          avl_waitrequest = 1'b0;
          ram_addr        = avl_address;
          ram_we          = avl_write;
          if (!avl_write) state_d = ST_CPU_RD;
        end else if (jtag_win) begin
          ram_addr = jaddr_q;
          if (pend_rd_q) begin
            state_d = ST_JTAG_RD;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = jwdata_q;
            pend_d    = 1'b0;
            jaddr_d   = jaddr_q + ADDR_W'(1);
          end
        end
      end
      // Read data is passed straight through so it lines up with the valid pulse.
      ST_CPU_RD: begin
        avl_readdatavalid = ~reset;
        avl_readdata      = ram_rdata;
        state_d           = ST_IDLE;
      end
      ST_JTAG_RD: begin
        mon_d   = ram_rdata;
        rdy_d   = 1'b1;
        pend_d  = 1'b0;
        jaddr_d = jaddr_q + ADDR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending is still set throughout a JTAG access, so new commands cannot collide with it.
    if (take_action_ocimem_a || take_action_ocimem_b) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        jaddr_d = jdo[ADDR_W+1:2];
        rdy_d   = 1'b0;
        if (jdo[35]) begin
          pend_d    = 1'b1;
          pend_rd_d = 1'b1;
        end
        if (take_action_ocimem_b) ovr_d = 1'b1;
      end else begin
        jwdata_d  = jdo[34:3];
        rdy_d     = 1'b0;
        pend_d    = 1'b1;
        pend_rd_d = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= RR_INIT;
      jaddr_q   <= '0;
      jwdata_q  <= '0;
      pend_q    <= 1'b0;
      pend_rd_q <= 1'b0;
      mon_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      jaddr_q   <= jaddr_d;
      jwdata_q  <= jwdata_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      mon_q     <= mon_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
      rdata_q   <= avl_readdata;
      raddr_q   <= ram_addr;
    end
  end

endmodule

// File: tb/tb_cpu_ocimem_access_arbiter.sv
// Bench for cpu_ocimem_access_arbiter: directed scenarios with literal checks,
// then randomized traffic compared each cycle against a transaction-level model.
module tb_cpu_ocimem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a, take_action_ocimem_b;
  logic [37:0] jdo;
  logic        debugack;
  logic [7:0]  avl_address;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  cpu_ocimem_access_arbiter #(.ADDR_W(8), .RR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo), .debugack(debugack),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_waitrequest(avl_waitrequest),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
  );

  // Single-port RAM attached to the DUT, 1-cycle read latency.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, JTAG command slot and outstanding read slot.
  logic [31:0] mmem [0:255];
  logic [7:0]  m_addr = '0, m_last = '0, m_slot_addr = '0;
  logic [31:0] m_wdata = '0, m_mon = '0, m_hold = '0;
  bit          m_pend = 0, m_prd = 0, m_rr = 0, m_rdy = 0, m_ovr = 0;
  int          m_slot = 0;   // 0 none, 1 CPU read data due, 2 JTAG read data due

  bit          e_wait, e_we, e_rdv, conflict;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  int          who;          // 0 none, 1 CPU, 2 JTAG

  bit          s_wait, s_we, s_rdv, s_rdy, s_ovr;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata, s_rdata, s_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    bit cpu, jt;
    e_wait = 1; e_we = 0; e_rdv = 0; e_addr = m_last; e_wdata = '0; e_rdata = m_hold;
    who = 0; conflict = 0;
    if (!reset) begin
      if (m_slot == 1) begin
        e_rdv   = 1;
        e_rdata = mmem[m_slot_addr];
      end else if (m_slot == 0) begin
        cpu = avl_read | avl_write;
        jt  = m_pend && debugack;
        conflict = cpu && jt;
        if (conflict) who = m_rr ? 2 : 1;
        else if (cpu) who = 1;
        else if (jt)  who = 2;
        if (who == 1) begin
          e_wait = 0; e_addr = avl_address; e_we = avl_write; e_wdata = avl_writedata;
        end else if (who == 2) begin
          e_addr = m_addr; e_we = !m_prd; e_wdata = m_wdata;
        end
      end
    end
  endtask

  task automatic model_seq();
    bit was_pend;
    int old_slot;
    if (reset) begin
      m_addr = '0; m_last = '0; m_pend = 0; m_prd = 0; m_rr = 0;
      m_rdy = 0; m_ovr = 0; m_mon = '0; m_hold = '0; m_slot = 0;
    end else begin
      was_pend = m_pend;
      old_slot = m_slot;
      if (e_we) mmem[e_addr] = e_wdata;
      m_slot = 0;
      if (old_slot == 1) m_hold = mmem[m_slot_addr];
      if (old_slot == 2) begin
        m_mon = mmem[m_slot_addr]; m_rdy = 1; m_pend = 0; m_addr = m_addr + 8'd1;
      end
      if (who == 1 && !avl_write) begin m_slot = 1; m_slot_addr = avl_address; end
      if (who == 2) begin
        if (m_prd) begin m_slot = 2; m_slot_addr = m_addr; end
        else begin m_pend = 0; m_addr = m_addr + 8'd1; end
      end
      if (conflict) m_rr = (who == 1);
      m_last = e_addr;
      if (take_action_ocimem_a || take_action_ocimem_b) begin
        if (was_pend) m_ovr = 1;
        else if (take_action_ocimem_a) begin
          m_addr = jdo[9:2]; m_rdy = 0;
          if (jdo[35]) begin m_pend = 1; m_prd = 1; end
          if (take_action_ocimem_b) m_ovr = 1;
        end else begin
          m_wdata = jdo[34:3]; m_rdy = 0; m_pend = 1; m_prd = 0;
        end
      end
    end
  endtask

  // One clock cycle: inputs are already set just after a falling edge.
  task automatic step();
    #1;
    model_comb();
    s_wait = avl_waitrequest; s_we = ram_we; s_rdv = avl_readdatavalid;
    s_addr = ram_addr; s_wdata = ram_wdata; s_rdata = avl_readdata;
    s_mon = MonDReg; s_rdy = monitor_ready; s_ovr = jtag_overrun;
    chk("waitrequest", 32'(s_wait), 32'(e_wait));
    chk("ram_we", 32'(s_we), 32'(e_we));
    chk("readdatavalid", 32'(s_rdv), 32'(e_rdv));
    if (!reset) begin
      chk("ram_addr", 32'(s_addr), 32'(e_addr));
      chk("avl_readdata", s_rdata, e_rdata);
      chk("MonDReg", s_mon, m_mon);
      chk("monitor_ready", 32'(s_rdy), 32'(m_rdy));
      chk("jtag_overrun", 32'(s_ovr), 32'(m_ovr));
      if (e_we) chk("ram_wdata", s_wdata, e_wdata);
    end
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic cmd_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d; take_action_ocimem_b = 1;
    step();
    take_action_ocimem_b = 0;
  endtask

  initial begin
    bit cpu_act;
    int k;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; mmem[i] = '0; end
    reset = 1; take_action_ocimem_a = 0; take_action_ocimem_b = 0; jdo = '0;
    debugack = 0; avl_address = '0; avl_read = 0; avl_write = 0; avl_writedata = '0;
    @(negedge clk);
    step(); step();
    reset = 0;
    step();
    chk("rst_wait", 32'(s_wait), 32'd1);
    chk("rst_mon", s_mon, 32'd0);
    chk("rst_ovr", 32'(s_ovr), 32'd0);

    // T1: CPU write then read back
    avl_write = 1; avl_address = 8'h05; avl_writedata = 32'h12345678;
    step(); chk("t1_wr_accept", 32'(s_wait), 32'd0);
    avl_write = 0; avl_read = 1;
    step(); chk("t1_rd_accept", 32'(s_wait), 32'd0);
    avl_read = 0;
    step(); chk("t1_rdv", 32'(s_rdv), 32'd1); chk("t1_rdata", s_rdata, 32'h12345678);

    // T2: JTAG read of 0x10 into MonDReg, then write lands at 0x11
    avl_write = 1; avl_address = 8'h10; avl_writedata = 32'hCAFEF00D;
    step();
    avl_write = 0; debugack = 1;
    jdo = '0; jdo[35] = 1; jdo[9:2] = 8'h10; take_action_ocimem_a = 1;
    step();
    take_action_ocimem_a = 0;
    step(); chk("t2_grant_addr", 32'(s_addr), 32'h10);
    step();
    step(); chk("t2_mon", s_mon, 32'hCAFEF00D); chk("t2_rdy", 32'(s_rdy), 32'd1);
    cmd_b(32'hA5A50001);
    step(); chk("t2_next_addr", 32'(s_addr), 32'h11); chk("t2_we", 32'(s_we), 32'd1);
    chk("t2_rdy_clr", 32'(s_rdy), 32'd0);

    // T3: round-robin between CPU and JTAG writes
    cmd_b(32'h0000BEEF);
    avl_write = 1; avl_address = 8'h20; avl_writedata = 32'h11111111;
    step(); chk("t3_cpu_first", 32'(s_wait), 32'd0); chk("t3_cpu_addr", 32'(s_addr), 32'h20);
    avl_write = 0;
    step(); chk("t3_jtag_next", 32'(s_addr), 32'h12); chk("t3_jtag_we", 32'(s_we), 32'd1);
    cmd_b(32'h00002222);
    avl_write = 1; avl_address = 8'h21; avl_writedata = 32'h33333333;
    step(); chk("t3_jtag_first", 32'(s_wait), 32'd1); chk("t3_jtag_addr", 32'(s_addr), 32'h13);
    step(); chk("t3_cpu_second", 32'(s_wait), 32'd0); chk("t3_cpu_addr2", 32'(s_addr), 32'h21);
    avl_write = 0;

    // T4/T5: held while debugack=0, overrun on second command, address wrap
    debugack = 0;
    jdo = '0; jdo[9:2] = 8'hFF; take_action_ocimem_a = 1;
    step();
    take_action_ocimem_a = 0;
    cmd_b(32'hDEAD00FF);
    step(); step(); step();
    cmd_b(32'h00000BAD);
    for (int i = 0; i < 16; i++) begin
      step(); chk("t4_no_we", 32'(s_we), 32'd0); chk("t5_overrun", 32'(s_ovr), 32'd1);
    end
    debugack = 1;
    step(); chk("t4_we", 32'(s_we), 32'd1); chk("t5_addr_ff", 32'(s_addr), 32'hFF);
    chk("t4_wdata", s_wdata, 32'hDEAD00FF);
    cmd_b(32'h0BADC0DE);
    step(); chk("t5_wrap", 32'(s_addr), 32'h00); chk("t5_ram_ff", ram[8'hFF], 32'hDEAD00FF);

    // T6: reset during an outstanding CPU read
    avl_read = 1; avl_address = 8'h05;
    step(); chk("t6_accept", 32'(s_wait), 32'd0);
    avl_read = 0; reset = 1;
    step(); chk("t6_no_rdv", 32'(s_rdv), 32'd0);
    reset = 0;
    step(); chk("t6_wait", 32'(s_wait), 32'd1); chk("t6_ovr", 32'(s_ovr), 32'd0);
    chk("t6_mon", s_mon, 32'd0); chk("t6_rdata", s_rdata, 32'd0); chk("t6_we", 32'(s_we), 32'd0);

    // Randomized traffic against the model
    cpu_act = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!cpu_act && $urandom_range(0, 2) == 0) begin
        cpu_act = 1;
        k = $urandom_range(0, 4);
        avl_read  = (k <= 1) || (k == 4);
        avl_write = (k >= 2);
        avl_address   = 8'($urandom_range(0, 31));
        avl_writedata = $urandom;
      end
      if (i % 50 == 0) debugack = ($urandom_range(0, 3) != 0);
      take_action_ocimem_a = ($urandom_range(0, 9) == 0);
      take_action_ocimem_b = ($urandom_range(0, 9) == 0);
      jdo = {6'($urandom), 32'($urandom)};
      jdo[9:2] = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(248, 255));
      step();
      if (reset || (cpu_act && !e_wait)) begin
        cpu_act = 0; avl_read = 0; avl_write = 0;
      end
    end
    reset = 0; take_action_ocimem_a = 0; take_action_ocimem_b = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
